// File: rtl/rr_prio_arbiter.sv
// Round-robin / fixed-priority arbiter with a registered, non-preemptive grant.
// Once a unit is granted, it keeps the grant until it drops its request.
// At that point the grant moves straight to the next winner, with no idle cycle.
module rr_prio_arbiter #(
    parameter int NUMUNITS     = 4,
    parameter int ADDRESSWIDTH = 2
) (
    input  logic                             clock,
    input  logic                             rst,
    input  logic                             roundORpriority,
    input  logic [NUMUNITS-1:0]              request,
    input  logic [ADDRESSWIDTH*NUMUNITS-1:0] priorit,
    output logic [NUMUNITS-1:0]              grant,
    output logic [ADDRESSWIDTH-1:0]          grant_idx
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [ADDRESSWIDTH-1:0] LAST_RESET = ADDRESSWIDTH'(NUMUNITS - 1);

    state_t                  state, state_nxt;
    logic [NUMUNITS-1:0]     grant_nxt;
    logic [ADDRESSWIDTH-1:0] grant_idx_nxt;
    logic [ADDRESSWIDTH-1:0] last_idx, last_idx_nxt;
    logic [ADDRESSWIDTH-1:0] winner;

    // Round-robin pick: first requester above last, wrapping modulo NUMUNITS.
    // The last unit itself is searched last.
    function automatic logic [ADDRESSWIDTH-1:0] rr_pick(
        input logic [NUMUNITS-1:0]     req,
        input logic [ADDRESSWIDTH-1:0] last
    );
        logic [ADDRESSWIDTH-1:0] pick;
        logic                    found;
        int                      idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUMUNITS; k++) begin
            idx = int'(last) + k;
            if (idx >= NUMUNITS) idx = idx - NUMUNITS;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = ADDRESSWIDTH'(idx);
            end
        end
        return pick;
    endfunction

    // Priority pick: largest priority field wins.
    // The strict compare leaves ties with the lowest index.
    function automatic logic [ADDRESSWIDTH-1:0] prio_pick(
        input logic [NUMUNITS-1:0]              req,
        input logic [ADDRESSWIDTH*NUMUNITS-1:0] prio
    );
        logic [ADDRESSWIDTH-1:0] pick;
        logic [ADDRESSWIDTH-1:0] best;
        logic                    found;
        pick  = '0;
        best  = '0;
        found = 1'b0;
        for (int i = 0; i < NUMUNITS; i++) begin
            if (req[i] && (!found || prio[ADDRESSWIDTH*i +: ADDRESSWIDTH] > best)) begin
                found = 1'b1;
                best  = prio[ADDRESSWIDTH*i +: ADDRESSWIDTH];
                pick  = ADDRESSWIDTH'(i);
            end
        end
        return pick;
    endfunction

    // Winner among the current requests.
    // It is only used when the holder has dropped its request, so the holder is already excluded.
    always_comb begin
        winner = '0;
        if (roundORpriority) winner = prio_pick(request, priorit);
        else                 winner = rr_pick(request, last_idx);
    end

    // Next-state logic: arbitrate from IDLE or on holder release, otherwise hold.
    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        grant_idx_nxt = grant_idx;
        last_idx_nxt  = last_idx;
        case (state)
            IDLE: begin
                if (request != '0) begin
                    state_nxt     = BUSY;
                    grant_nxt     = NUMUNITS'(1) << winner;
                    grant_idx_nxt = winner;
                    last_idx_nxt  = winner;
                end else begin
                    grant_nxt     = '0;
                    grant_idx_nxt = '0;
                end
            end
            BUSY: begin
                if (request[grant_idx]) begin
                    state_nxt = BUSY;
                end else if (request != '0) begin
                    grant_nxt     = NUMUNITS'(1) << winner;
                    grant_idx_nxt = winner;
                    last_idx_nxt  = winner;
                end else begin
                    state_nxt     = IDLE;
                    grant_nxt     = '0;
                    grant_idx_nxt = '0;
                end
            end
            default: begin
                state_nxt     = IDLE;
                grant_nxt     = '0;
                grant_idx_nxt = '0;
            end
        endcase
    end

    // State and grant registers.
    // Reset clears the grant immediately and primes the pointer so unit 0 wins first.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            last_idx  <= LAST_RESET;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            grant_idx <= grant_idx_nxt;
            last_idx  <= last_idx_nxt;
        end
    end

endmodule

// File: tb/tb_rr_prio_arbiter.sv
// Directed bench for rr_prio_arbiter (NUMUNITS=4, ADDRESSWIDTH=2).
module tb_rr_prio_arbiter;

    logic       clock = 1'b0;
    logic       rst;
    logic       roundORpriority;
    logic [3:0] request;
    logic [7:0] priorit;
    logic [3:0] grant;
    logic [1:0] grant_idx;

    int checks = 0;
    int errors = 0;

    rr_prio_arbiter #(.NUMUNITS(4), .ADDRESSWIDTH(2)) dut (
        .clock          (clock),
        .rst            (rst),
        .roundORpriority(roundORpriority),
        .request        (request),
        .priorit        (priorit),
        .grant          (grant),
        .grant_idx      (grant_idx)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       mode;
        logic [3:0] req;
        logic [7:0] prio;
        logic [3:0] exp_grant;
        logic [1:0] exp_idx;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [3:0] exp_g, input logic [1:0] exp_i);
        checks++;
        if (grant !== exp_g || grant_idx !== exp_i) begin
            errors++;
            $display("FAIL %s: grant=%b idx=%0d, expected grant=%b idx=%0d",
                     name, grant, grant_idx, exp_g, exp_i);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Every cycle: the grant is one-hot or zero, and a set bit matches grant_idx.
    always @(negedge clock) begin
        checks++;
        if (!((grant == 4'b0000 && grant_idx == 2'd0) ||
              (grant == (4'b0001 << grant_idx)))) begin
            errors++;
            $display("FAIL onehot_consistency: grant=%b idx=%0d, expected one-hot at idx or zero",
                     grant, grant_idx);
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        // mode, request, priorit, expected grant, expected idx (history-dependent)
        vecs[0]  = '{1'b0, 4'b1111, 8'h00, 4'b0001, 2'd0};
        vecs[1]  = '{1'b0, 4'b1110, 8'h00, 4'b0010, 2'd1};
        vecs[2]  = '{1'b0, 4'b1101, 8'h00, 4'b0100, 2'd2};
        vecs[3]  = '{1'b0, 4'b1011, 8'h00, 4'b1000, 2'd3};
        vecs[4]  = '{1'b0, 4'b0111, 8'h00, 4'b0001, 2'd0};
        vecs[5]  = '{1'b1, 4'b0001, 8'hFF, 4'b0001, 2'd0};
        vecs[6]  = '{1'b0, 4'b0000, 8'h00, 4'b0000, 2'd0};
        vecs[7]  = '{1'b1, 4'b1111, 8'b00_10_01_11, 4'b0001, 2'd0};
        vecs[8]  = '{1'b1, 4'b1010, 8'b10_10_10_10, 4'b0010, 2'd1};
        vecs[9]  = '{1'b1, 4'b0000, 8'h00, 4'b0000, 2'd0};
        vecs[10] = '{1'b1, 4'b1001, 8'b11_00_00_00, 4'b1000, 2'd3};
        vecs[11] = '{1'b0, 4'b0001, 8'h00, 4'b0001, 2'd0};
        vecs[12] = '{1'b0, 4'b0000, 8'h00, 4'b0000, 2'd0};
        vecs[13] = '{1'b0, 4'b0110, 8'h00, 4'b0010, 2'd1};
        vecs[14] = '{1'b1, 4'b0110, 8'h00, 4'b0010, 2'd1};
        vecs[15] = '{1'b1, 4'b0100, 8'b00_01_00_00, 4'b0100, 2'd2};
        vecs[16] = '{1'b0, 4'b0000, 8'h00, 4'b0000, 2'd0};
        vecs[17] = '{1'b0, 4'b1001, 8'h00, 4'b1000, 2'd3};
        vecs[18] = '{1'b0, 4'b0001, 8'h00, 4'b0001, 2'd0};
        vecs[19] = '{1'b0, 4'b0000, 8'h00, 4'b0000, 2'd0};

        rst = 1'b1;
        roundORpriority = 1'b0;
        request = 4'b0000;
        priorit = 8'h00;
        step();
        step();
        chk("reset_state", 4'b0000, 2'd0);
        rst = 1'b0;

        for (int v = 0; v < 20; v++) begin
            roundORpriority = vecs[v].mode;
            request         = vecs[v].req;
            priorit         = vecs[v].prio;
            step();
            chk($sformatf("vec%0d", v), vecs[v].exp_grant, vecs[v].exp_idx);
        end

        // Async reset mid-grant: grant drops before the next edge.
        roundORpriority = 1'b0;
        request = 4'b0100;
        step();
        chk("pre_reset_grant", 4'b0100, 2'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_drop", 4'b0000, 2'd0);
        request = 4'b1111;
        @(posedge clock);
        #1;
        chk("no_arb_in_reset", 4'b0000, 2'd0);
        rst = 1'b0;
        step();
        chk("first_after_reset", 4'b0001, 2'd0);

        // No preemption: holder 2 keeps the grant despite a higher-priority requester.
        request = 4'b0100;
        step();
        chk("move_to_unit2", 4'b0100, 2'd2);
        roundORpriority = 1'b1;
        priorit = 8'b00_00_00_11;
        request = 4'b0101;
        step();
        chk("hold_vs_prio_1", 4'b0100, 2'd2);
        step();
        chk("hold_vs_prio_2", 4'b0100, 2'd2);
        request = 4'b0001;
        step();
        chk("release_to_unit0", 4'b0001, 2'd0);

        // Idle return, then a fresh request after a quiet cycle.
        request = 4'b0000;
        step();
        chk("idle_return", 4'b0000, 2'd0);
        step();
        chk("idle_stays_zero", 4'b0000, 2'd0);
        request = 4'b0010;
        step();
        chk("grant_from_idle", 4'b0010, 2'd1);

        request = 4'b0000;
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_prio_arbiter.md
RR_PRIO_ARBITER -- requirements
Module: rr_prio_arbiter

Interface
REQ-001 Parameter NUMUNITS, default 4, number of requesting units (2..16).
REQ-002 Parameter ADDRESSWIDTH, default 2, bits to index NUMUNITS; also width of each priority field.
REQ-003 clock  input  1  rising-edge clock; the block's only clock.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 roundORpriority  input  1  arbitration mode: 0 = round-robin, 1 = fixed priority.
REQ-006 request  input  NUMUNITS  request[i]=1 means unit i requests the resource.
REQ-007 priorit  input  ADDRESSWIDTH*NUMUNITS  unit i priority = priorit[ADDRESSWIDTH*i +: ADDRESSWIDTH]; larger value wins.
REQ-008 grant  output  NUMUNITS  registered grant, one-hot or all-zero.
REQ-009 grant_idx  output  ADDRESSWIDTH  registered index of the granted unit; 0 when grant is all-zero.

Function
REQ-010 The FSM SHALL have two states: IDLE (no grant) and BUSY (one unit granted).
REQ-011 In IDLE, at each rising edge with request != 0, the block SHALL arbitrate, load the winner into grant/grant_idx, and enter BUSY; request-to-grant latency = 1 cycle.
REQ-012 In IDLE with request == 0, grant SHALL stay all-zero.
REQ-013 In BUSY, while request[grant_idx] = 1 at the edge, grant SHALL be held unchanged (no preemption by any mode, priority or request change).
REQ-014 In BUSY, when request[grant_idx] = 0 at the edge and other requests are pending, the block SHALL arbitrate among the current request bits (holder excluded) and switch grant directly to the winner in that same edge, with no idle cycle.
REQ-015 In BUSY, when request == 0 at the edge, grant SHALL go to all-zero and the FSM SHALL return to IDLE.
REQ-016 A pointer last_idx SHALL record the index of the most recently granted unit, updated on every new grant in either mode.
REQ-017 Round-robin mode: the winner SHALL be the first requesting index searched upward from last_idx+1, wrapping from NUMUNITS-1 to 0; last_idx itself is searched last.
REQ-018 Priority mode: the winner SHALL be the requesting unit with the largest priority field; ties go to the lowest index.
REQ-019 roundORpriority and priorit SHALL be sampled only when an arbitration takes place; changes during a held grant have no effect until the next arbitration.
REQ-020 grant SHALL never have more than one bit set, and a set bit SHALL always equal bit grant_idx.
REQ-021 Requests from indices >= NUMUNITS cannot exist; the pointer wrap SHALL be modulo NUMUNITS, correct for non-power-of-two NUMUNITS.

Reset
REQ-022 Asserting rst SHALL immediately, without waiting for a clock edge, set grant = 0, grant_idx = 0, FSM = IDLE, last_idx = NUMUNITS-1, so unit 0 wins the first round-robin arbitration.
REQ-023 While rst = 1, no arbitration SHALL occur; the first arbitration is at the first rising edge after rst deasserts.
REQ-024 Reset asserted mid-grant SHALL drop grant in the same cycle, not at the next edge.

Verification (NUMUNITS=4, ADDRESSWIDTH=2)
REQ-025 Async reset: with grant=0100, raise rst between edges -> grant=0000 and grant_idx=0 before the next edge; release rst with request=1111 and mode 0 -> grant=0001 after one edge.
REQ-026 Round-robin rotation: mode 0, request=1111; the bench clears the holder's bit for one cycle after each one-cycle grant -> grants 0001, 0010, 0100, 1000, 0001 with no zero cycles between them.
REQ-027 Priority and tie: mode 1, priorit=8'b00_10_01_11, request=1111 -> grant=0001; priorit=8'b10_10_10_10, request=1010 -> grant=0010.
REQ-028 No preemption: grant=0100 held, then request[0] asserted with mode 1 and the highest priority -> grant stays 0100 while request[2]=1; drop request[2] -> grant=0001 next edge.
REQ-029 Idle return: holder drops its request while request becomes 0000 -> grant=0000 and grant_idx=0 next edge; FSM in IDLE; a later request=0010 -> grant=0010 one edge later.
REQ-030 A bench assertion SHALL check REQ-020 (one-hot or zero, and consistency with grant_idx) every cycle across all scenarios.
